// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: bundles the cache-side request/response signals and the shared RAM port
// signals seen by ram_port_arbiter.
//   slave  modport - used by the arbiter (takes requests and RAM status, drives RAM and stalls)
//   master modport - used by the environment (cache controllers plus RAM model)
// Packed per-requester vectors: requester i occupies [i*W +: W].
interface ram_port_arbiter_if #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned ID_W = $clog2(NREQ);

    // Cache side
    logic [NREQ-1:0]        req_ren;
    logic [NREQ-1:0]        req_wen;
    logic [NREQ-1:0]        req_lock;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_store;
    logic [NREQ-1:0]        req_wait;
    logic [NREQ*DATA_W-1:0] req_load;
    logic [NREQ-1:0]        req_err;

    // RAM side
    logic                   ramREN;
    logic                   ramWEN;
    logic [ADDR_W-1:0]      ramaddr;
    logic [DATA_W-1:0]      ramstore;
    logic [DATA_W-1:0]      ramload;
    logic [1:0]             ramstate;

    // Status
    logic [ID_W-1:0]        grant_id;
    logic                   busy;

    modport slave (
        input  req_ren, req_wen, req_lock, req_addr, req_store, ramload, ramstate,
        output req_wait, req_load, req_err, ramREN, ramWEN, ramaddr, ramstore, grant_id, busy
    );

    modport master (
        output req_ren, req_wen, req_lock, req_addr, req_store, ramload, ramstate,
        input  req_wait, req_load, req_err, ramREN, ramWEN, ramaddr, ramstore, grant_id, busy
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin sharing of one RAM port among NREQ cache requesters.
// IDLE picks the first pending requester at or after the rr pointer (one grant cycle, RAM
// enables low). ACTIVE forwards the owner's request to RAM combinationally until ACCESS
// (completion), ERROR / watchdog expiry (abort with req_err pulse) or the owner dropping its
// request. A held req_lock keeps ownership across consecutive completions.
// Ports:
//   CLK  - clock, rising edge
//   nRST - asynchronous active-low reset
//   bus  - ram_port_arbiter_if.slave: per-requester ren/wen/lock/addr/store in, wait/load/err
//          out; RAM REN/WEN/addr/store out, load/state in; grant_id and busy status out
module ram_port_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input logic               CLK,
    input logic               nRST,
    ram_port_arbiter_if.slave bus
);
    localparam int unsigned     ID_W       = $clog2(NREQ);
    localparam int unsigned     WD_W       = $clog2(TIMEOUT);
    localparam logic [1:0]      RAM_ACCESS = 2'd2;
    localparam logic [1:0]      RAM_ERROR  = 2'd3;
    localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0] ID_LAST    = ID_W'(NREQ - 1);

    typedef enum logic {IDLE, ACTIVE} state_e;

    state_e          state_q;
    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] owner_q;
    logic [WD_W-1:0] wdog_q;

    logic [NREQ-1:0]        pending;
    logic [ID_W-1:0]        pick;
    logic                   pick_found;
    logic [ID_W-1:0]        owner_inc;
    int                     cand;
    logic                   own_ren, own_wen, own_lock;
    logic [ADDR_W-1:0]      own_addr;
    logic [DATA_W-1:0]      own_store;
    logic                   active, access, abort, dropped;
    logic [NREQ-1:0]        wait_vec, err_vec;
    logic [NREQ*DATA_W-1:0] load_vec;

    assign pending = bus.req_ren | bus.req_wen;

    // Scan offsets from high to low so the smallest offset from the pointer wins.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        cand       = 0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            cand = int'(ptr_q) + i;
            if (cand >= int'(NREQ)) cand = cand - int'(NREQ);
            if (pending[cand]) begin
                pick       = ID_W'(cand);
                pick_found = 1'b1;
            end
        end
    end

    // Owner's request fields.
    always_comb begin
        own_ren   = 1'b0;
        own_wen   = 1'b0;
        own_lock  = 1'b0;
        own_addr  = '0;
        own_store = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (owner_q == ID_W'(i)) begin
                own_ren   = bus.req_ren[i];
                own_wen   = bus.req_wen[i];
                own_lock  = bus.req_lock[i];
                own_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                own_store = bus.req_store[i*DATA_W +: DATA_W];
            end
        end
    end

    assign owner_inc = (owner_q == ID_LAST) ? '0 : owner_q + 1'b1;

    assign active  = (state_q == ACTIVE);
    assign access  = active && (bus.ramstate == RAM_ACCESS);
    assign dropped = active && !own_ren && !own_wen;
    // ACCESS beats abort; an owner that has already left gets no error pulse.
    assign abort   = active && !access && !dropped &&
                     ((bus.ramstate == RAM_ERROR) || (wdog_q == WD_LAST));

    assign bus.ramWEN   = active & own_wen;
    assign bus.ramREN   = active & own_ren & ~own_wen;
    assign bus.ramaddr  = active ? own_addr : '0;
    assign bus.ramstore = (active && own_wen) ? own_store : '0;
    assign bus.grant_id = owner_q;
    assign bus.busy     = active;

    always_comb begin
        wait_vec = '1;
        err_vec  = '0;
        load_vec = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (owner_q == ID_W'(i)) begin
                wait_vec[i]                  = ~access;
                err_vec[i]                   = abort;
                load_vec[i*DATA_W +: DATA_W] = active ? bus.ramload : '0;
            end
        end
    end

    assign bus.req_wait = wait_vec;
    assign bus.req_err  = err_vec;
    assign bus.req_load = load_vec;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            wdog_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        owner_q <= pick;
                        wdog_q  <= '0;
                        state_q <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (access && own_lock && (own_ren || own_wen)) begin
                        // Locked burst: keep the port, restart the watchdog for the next word.
                        wdog_q <= '0;
                    end else if (access || abort || dropped) begin
                        state_q <= IDLE;
                        ptr_q   <= owner_inc;
                        wdog_q  <= '0;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter (NREQ=4, 32-bit, TIMEOUT=8).
// Each task drives one scenario and checks inline; completions and error pulses are checked
// by a scoreboard monitor against events queued when the RAM response is driven.
module tb_ram_port_arbiter;
    localparam int unsigned NREQ = 4;
    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned TO   = 8;

    localparam logic [1:0] ST_FREE   = 2'd0;
    localparam logic [1:0] ST_BUSY   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_ERROR  = 2'd3;

    typedef struct packed {
        logic [1:0]  id;
        logic        err;
        logic [31:0] load;
    } exp_t;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    ram_port_arbiter_if #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_port_arbiter #(
        .NREQ   (NREQ),
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TO)
    ) dut (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Scoreboard monitor: any completion (a wait bit low) or error pulse must match the next
    // queued event.
    exp_t           m_e;
    logic [3:0]     m_wait, m_err;
    logic [127:0]   m_load;
    always @(negedge CLK) begin
        if (nRST === 1'b1 && (bus.req_wait !== 4'hF || bus.req_err !== 4'h0)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got wait=%b err=%b, required no event",
                         bus.req_wait, bus.req_err);
            end else begin
                m_e    = sb.pop_front();
                m_wait = m_e.err ? 4'hF : ~(4'b0001 << m_e.id);
                m_err  = m_e.err ? (4'b0001 << m_e.id) : 4'h0;
                if (bus.req_wait !== m_wait || bus.req_err !== m_err || bus.grant_id !== m_e.id)
                begin
                    errors++;
                    $display("FAIL sb_event: got wait=%b err=%b id=%0d, required wait=%b err=%b id=%0d",
                             bus.req_wait, bus.req_err, bus.grant_id, m_wait, m_err, m_e.id);
                end
                if (!m_e.err) begin
                    checks++;
                    m_load = '0;
                    m_load[m_e.id*32 +: 32] = m_e.load;
                    if (bus.req_load !== m_load) begin
                        errors++;
                        $display("FAIL sb_load: got %h, required %h", bus.req_load, m_load);
                    end
                end
            end
        end
    end

    task automatic test_reset;
        bus.req_ren = 4'hF; bus.req_wen = 4'h0; bus.req_lock = 4'h0;
        bus.req_addr = '0; bus.req_store = '0; bus.ramload = '0; bus.ramstate = ST_FREE;
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (bus.req_wait !== 4'hF || bus.req_err !== 4'h0 || bus.req_load !== '0) begin
            errors++;
            $display("FAIL reset_req: got wait=%b err=%b load=%h, required F/0/0",
                     bus.req_wait, bus.req_err, bus.req_load);
        end
        checks++;
        if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0 || bus.ramaddr !== '0 ||
            bus.ramstore !== '0) begin
            errors++;
            $display("FAIL reset_ram: got ren=%b wen=%b addr=%h store=%h, required zeros",
                     bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore);
        end
        checks++;
        if (bus.grant_id !== 2'd0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: got id=%0d busy=%b, required 0/0", bus.grant_id, bus.busy);
        end
        bus.req_ren = 4'h0;
        #2 nRST = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_single_read;
        bus.req_ren[2] = 1'b1;
        bus.req_addr[2*AW +: AW] = 32'h40;
        bus.req_store[2*DW +: DW] = 32'hFFFF_0000;
        bus.ramstate = ST_FREE;
        @(negedge CLK);
        checks++;
        if (bus.busy !== 1'b0 || bus.ramREN !== 1'b0) begin
            errors++;
            $display("FAIL rd_grant_cycle: got busy=%b ren=%b, required 0/0", bus.busy, bus.ramREN);
        end
        @(posedge CLK); #1;
        bus.ramstate = ST_BUSY;
        @(negedge CLK);
        checks++;
        if (bus.busy !== 1'b1 || bus.grant_id !== 2'd2 || bus.ramREN !== 1'b1 ||
            bus.ramWEN !== 1'b0 || bus.ramaddr !== 32'h40 || bus.ramstore !== 32'h0) begin
            errors++;
            $display("FAIL rd_active: got busy=%b id=%0d ren=%b wen=%b addr=%h store=%h, required 1/2/1/0/40/0",
                     bus.busy, bus.grant_id, bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore);
        end
        @(posedge CLK); #1;
        @(negedge CLK);
        checks++;
        if (bus.req_wait !== 4'hF) begin
            errors++;
            $display("FAIL rd_stall: got wait=%b, required 1111", bus.req_wait);
        end
        @(posedge CLK); #1;
        bus.ramstate = ST_ACCESS;
        bus.ramload = 32'hDEAD_BEEF;
        sb.push_back(exp_t'{2'd2, 1'b0, 32'hDEAD_BEEF});
        @(negedge CLK);
        @(posedge CLK); #1;
        // Pointer is now 3: with 0 and 3 pending, 3 must win.
        bus.ramstate = ST_FREE;
        bus.req_ren = 4'b1001;
        @(negedge CLK);
        checks++;
        if (bus.busy !== 1'b0 || bus.req_wait !== 4'hF) begin
            errors++;
            $display("FAIL rd_back_idle: got busy=%b wait=%b, required 0/1111", bus.busy, bus.req_wait);
        end
        @(posedge CLK); #1;
        @(negedge CLK);
        checks++;
        if (bus.busy !== 1'b1 || bus.grant_id !== 2'd3) begin
            errors++;
            $display("FAIL rd_ptr_after: got busy=%b id=%0d, required 1/3", bus.busy, bus.grant_id);
        end
        @(posedge CLK); #1;
        bus.req_ren = 4'h0;
        @(negedge CLK);
        checks++;
        if (bus.ramREN !== 1'b0 || bus.busy !== 1'b1 || bus.req_err !== 4'h0) begin
            errors++;
            $display("FAIL drop_same_cycle: got ren=%b busy=%b err=%b, required 0/1/0000",
                     bus.ramREN, bus.busy, bus.req_err);
        end
        @(posedge CLK); #1;
        @(negedge CLK);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL drop_idle: got busy=%b, required 0", bus.busy);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_round_robin;
        logic [1:0] want;
        for (int i = 0; i < 4; i++) bus.req_addr[i*AW +: AW] = 32'h1000 + 32'(i) * 32'h100;
        bus.req_ren = 4'hF;
        for (int k = 0; k < 5; k++) begin
            want = 2'(k % 4);
            bus.ramstate = ST_FREE;
            @(negedge CLK);
            checks++;
            if (bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL rr_idle_%0d: got busy=%b, required 0", k, bus.busy);
            end
            @(posedge CLK); #1;
            for (int c = 0; c < 3; c++) begin
                bus.ramstate = (c == 2) ? ST_ACCESS : ST_BUSY;
                if (c == 2) begin
                    bus.ramload = 32'h1000_0000 + 32'(k);
                    sb.push_back(exp_t'{want, 1'b0, 32'h1000_0000 + 32'(k)});
                end
                @(negedge CLK);
                if (c == 0) begin
                    checks++;
                    if (bus.grant_id !== want ||
                        bus.ramaddr !== 32'h1000 + 32'(want) * 32'h100) begin
                        errors++;
                        $display("FAIL rr_grant_%0d: got id=%0d addr=%h, required id=%0d",
                                 k, bus.grant_id, bus.ramaddr, want);
                    end
                end
                @(posedge CLK); #1;
            end
        end
        bus.req_ren = 4'h0;
        bus.ramstate = ST_FREE;
        @(negedge CLK);
        @(posedge CLK); #1;
    endtask

    task automatic test_lock_burst;
        bus.req_wen = 4'b0010; bus.req_lock = 4'b0010; bus.req_ren = 4'b0001;
        bus.req_addr[1*AW +: AW] = 32'h80; bus.req_store[1*DW +: DW] = 32'hA0;
        bus.req_addr[0*AW +: AW] = 32'h10;
        bus.ramstate = ST_FREE;
        @(negedge CLK);
        @(posedge CLK); #1;
        bus.ramstate = ST_BUSY;
        @(negedge CLK);
        checks++;
        if (bus.grant_id !== 2'd1 || bus.ramWEN !== 1'b1 || bus.ramaddr !== 32'h80 ||
            bus.ramstore !== 32'hA0) begin
            errors++;
            $display("FAIL lock_w0: got id=%0d wen=%b addr=%h store=%h, required 1/1/80/a0",
                     bus.grant_id, bus.ramWEN, bus.ramaddr, bus.ramstore);
        end
        @(posedge CLK); #1;
        bus.ramstate = ST_ACCESS; bus.ramload = 32'h5555;
        sb.push_back(exp_t'{2'd1, 1'b0, 32'h5555});
        @(negedge CLK);
        @(posedge CLK); #1;
        bus.ramstate = ST_BUSY; bus.req_lock = 4'h0;
        bus.req_addr[1*AW +: AW] = 32'h84; bus.req_store[1*DW +: DW] = 32'hA4;
        @(negedge CLK);
        checks++;
        if (bus.busy !== 1'b1 || bus.grant_id !== 2'd1 || bus.ramaddr !== 32'h84) begin
            errors++;
            $display("FAIL lock_hold: got busy=%b id=%0d addr=%h, required 1/1/84",
                     bus.busy, bus.grant_id, bus.ramaddr);
        end
        @(posedge CLK); #1;
        bus.ramstate = ST_ACCESS; bus.ramload = 32'h6666;
        sb.push_back(exp_t'{2'd1, 1'b0, 32'h6666});
        @(negedge CLK);
        @(posedge CLK); #1;
        bus.req_wen = 4'h0; bus.ramstate = ST_FREE;
        @(negedge CLK);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL lock_release: got busy=%b, required 0", bus.busy);
        end
        @(posedge CLK); #1;
        bus.ramstate = ST_ACCESS; bus.ramload = 32'h7777;
        sb.push_back(exp_t'{2'd0, 1'b0, 32'h7777});
        @(negedge CLK);
        checks++;
        if (bus.grant_id !== 2'd0 || bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h10) begin
            errors++;
            $display("FAIL lock_next: got id=%0d ren=%b addr=%h, required 0/1/10",
                     bus.grant_id, bus.ramREN, bus.ramaddr);
        end
        @(posedge CLK); #1;
        bus.req_ren = 4'h0; bus.ramstate = ST_FREE;
        @(negedge CLK);
        @(posedge CLK); #1;
    endtask

    task automatic test_write_priority;
        bus.req_ren = 4'b1000; bus.req_wen = 4'b1000;
        bus.req_addr[3*AW +: AW] = 32'hC0; bus.req_store[3*DW +: DW] = 32'h1234;
        bus.ramstate = ST_FREE;
        @(negedge CLK);
        @(posedge CLK); #1;
        bus.ramstate = ST_BUSY;
        @(negedge CLK);
        checks++;
        if (bus.grant_id !== 2'd3 || bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0 ||
            bus.ramstore !== 32'h1234) begin
            errors++;
            $display("FAIL wr_prio: got id=%0d wen=%b ren=%b store=%h, required 3/1/0/1234",
                     bus.grant_id, bus.ramWEN, bus.ramREN, bus.ramstore);
        end
        @(posedge CLK); #1;
        bus.ramstate = ST_ACCESS; bus.ramload = 32'h9999;
        sb.push_back(exp_t'{2'd3, 1'b0, 32'h9999});
        @(negedge CLK);
        @(posedge CLK); #1;
        bus.req_ren = 4'h0; bus.req_wen = 4'h0; bus.ramstate = ST_FREE;
        @(negedge CLK);
        @(posedge CLK); #1;
    endtask

    task automatic test_timeout;
        bus.req_ren = 4'b0010; bus.req_addr[1*AW +: AW] = 32'h200;
        bus.ramstate = ST_BUSY;
        @(negedge CLK);
        for (int c = 1; c <= int'(TO); c++) begin
            @(posedge CLK); #1;
            if (c == int'(TO)) sb.push_back(exp_t'{2'd1, 1'b1, 32'h0});
            @(negedge CLK);
            if (c < int'(TO)) begin
                checks++;
                if (bus.busy !== 1'b1 || bus.req_err !== 4'h0 || bus.req_wait !== 4'hF) begin
                    errors++;
                    $display("FAIL to_wait_%0d: got busy=%b err=%b wait=%b, required 1/0000/1111",
                             c, bus.busy, bus.req_err, bus.req_wait);
                end
            end
        end
        @(posedge CLK); #1;
        // Pointer advanced to 2: with 1 and 3 pending, 3 must win.
        bus.req_ren = 4'b1010; bus.ramstate = ST_FREE;
        @(negedge CLK);
        checks++;
        if (bus.busy !== 1'b0 || bus.req_err !== 4'h0) begin
            errors++;
            $display("FAIL to_idle: got busy=%b err=%b, required 0/0000", bus.busy, bus.req_err);
        end
        @(posedge CLK); #1;
        @(negedge CLK);
        checks++;
        if (bus.grant_id !== 2'd3) begin
            errors++;
            $display("FAIL to_ptr: got id=%0d, required 3", bus.grant_id);
        end
        @(posedge CLK); #1;
        bus.req_ren = 4'h0;
        @(negedge CLK);
        @(posedge CLK); #1;
    endtask

    task automatic test_error;
        bus.req_ren = 4'b0001; bus.req_lock = 4'b0001; bus.req_addr[0*AW +: AW] = 32'h400;
        bus.ramstate = ST_FREE;
        @(negedge CLK);
        @(posedge CLK); #1;
        bus.ramstate = ST_ERROR;
        sb.push_back(exp_t'{2'd0, 1'b1, 32'h0});
        @(negedge CLK);
        @(posedge CLK); #1;
        bus.ramstate = ST_FREE; bus.req_ren = 4'h0; bus.req_lock = 4'h0;
        @(negedge CLK);
        checks++;
        if (bus.busy !== 1'b0 || bus.req_err !== 4'h0) begin
            errors++;
            $display("FAIL err_ignore_lock: got busy=%b err=%b, required 0/0000",
                     bus.busy, bus.req_err);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_reset_mid_op;
        bus.req_wen = 4'b0100; bus.req_addr[2*AW +: AW] = 32'h300;
        bus.req_store[2*DW +: DW] = 32'h77; bus.ramstate = ST_BUSY;
        @(negedge CLK);
        @(posedge CLK); #1;
        @(negedge CLK);
        checks++;
        if (bus.ramWEN !== 1'b1 || bus.busy !== 1'b1 || bus.grant_id !== 2'd2) begin
            errors++;
            $display("FAIL rst_pre: got wen=%b busy=%b id=%0d, required 1/1/2",
                     bus.ramWEN, bus.busy, bus.grant_id);
        end
        #2 nRST = 1'b0;
        bus.req_wen = 4'h0; bus.req_ren = 4'b1001; bus.ramstate = ST_FREE;
        #1;
        checks++;
        if (bus.ramWEN !== 1'b0 || bus.busy !== 1'b0 || bus.req_wait !== 4'hF) begin
            errors++;
            $display("FAIL rst_async: got wen=%b busy=%b wait=%b, required 0/0/1111",
                     bus.ramWEN, bus.busy, bus.req_wait);
        end
        #1 nRST = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        checks++;
        if (bus.busy !== 1'b1 || bus.grant_id !== 2'd0) begin
            errors++;
            $display("FAIL rst_ptr: got busy=%b id=%0d, required 1/0", bus.busy, bus.grant_id);
        end
        @(posedge CLK); #1;
        bus.req_ren = 4'h0;
        @(negedge CLK);
        @(posedge CLK); #1;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock_burst();
        test_write_priority();
        test_timeout();
        test_error();
        test_reset_mid_op();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending events, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish by 100000, required finish");
        $fatal(1);
    end
endmodule
